// File: rtl/iq_pkg.sv
// Shared constants and types for the IQ mismatch compensator.
package iq_pkg;

    // Q-format limits
    localparam int Q15_MAX = 32767;
    localparam int Q15_MIN = -32768;
    localparam int Q14_ONE = 16384;

    // Coefficient clamp limits (Q2.14)
    localparam int GAIN_MIN  = 8192;
    localparam int GAIN_MAX  = 32767;
    localparam int PHASE_MIN = -16384;
    localparam int PHASE_MAX = 16383;

    typedef enum logic [0:0] {
        StAccum,
        StUpdate
    } iq_state_e;

endpackage

// File: rtl/iq_sat16.sv
// Combinational saturate-and-truncate of a signed value to signed 16 bits.
module iq_sat16
    import iq_pkg::*;
#(
    parameter int unsigned IN_W = 33
) (
    input  logic signed [IN_W-1:0] d_i,
    output logic signed [15:0]     q_o
);

    localparam logic signed [IN_W-1:0] SatHi = IN_W'(Q15_MAX);
    localparam logic signed [IN_W-1:0] SatLo = IN_W'(Q15_MIN);

    // Clamp to the Q1.15 range, otherwise keep the low 16 bits
    always_comb begin
        if (d_i > SatHi) begin
            q_o = 16'(Q15_MAX);
        end else if (d_i < SatLo) begin
            q_o = 16'(Q15_MIN);
        end else begin
            q_o = d_i[15:0];
        end
    end

endmodule

// File: rtl/iq_mismatch_comp.sv
// IQ gain/phase mismatch compensator: 2-stage correction pipeline plus a
// block-based power/correlation estimator that adapts the coefficients.
module iq_mismatch_comp
    import iq_pkg::*;
#(
    parameter int unsigned LOG2_N   = 10,
    parameter int unsigned MU_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] I_in,
    input  logic signed [15:0] Q_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] I_out,
    output logic signed [15:0] Q_out,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               est_en,
    input  logic               coef_ld,
    input  logic signed [15:0] coef_gain_in,
    input  logic signed [15:0] coef_phase_in,
    output logic signed [15:0] w_gain,
    output logic signed [15:0] w_phase,
    output logic               block_done
);

    localparam int unsigned ACC_W     = 32 + LOG2_N + 1;
    localparam int unsigned UPD_W     = ACC_W + 1;
    localparam int unsigned EST_SHIFT = LOG2_N + 16;
    localparam logic [LOG2_N-1:0] CntMax = '1;

    iq_state_e                 state_q, state_d;
    logic        [LOG2_N-1:0]  cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   pii_q, pii_d, pqq_q, pqq_d, ciq_q, ciq_d;
    logic signed [15:0]        wg_q, wg_d, wp_q, wp_d;

    logic                      s1_valid_q;
    logic signed [31:0]        s1_pg_q, s1_pp_q;
    logic signed [15:0]        s1_i_q;
    logic                      out_valid_q;
    logic signed [15:0]        i_out_q, q_out_q;

    logic                      en, in_xfer, out_xfer;
    logic signed [32:0]        sum, sum_shr;
    logic signed [15:0]        q_sat;
    logic signed [31:0]        p_ii, p_qq, c_iq;
    logic signed [ACC_W-1:0]   pdiff, g_step, p_step;
    logic signed [UPD_W-1:0]   g_sum, p_sum;
    logic signed [15:0]        g_new, p_new;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = rst_n && en && (state_q == StAccum);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign sum     = 33'(s1_pg_q) + 33'(s1_pp_q);
    assign sum_shr = sum >>> 14;

    iq_sat16 #(
        .IN_W (33)
    ) u_sat (
        .d_i (sum_shr),
        .q_o (q_sat)
    );

    // Datapath: stage 1 latches products with the coefficients current at
    // acceptance, so later coefficient changes never touch in-flight samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_pg_q     <= '0;
            s1_pp_q     <= '0;
            s1_i_q      <= '0;
            out_valid_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else if (en) begin
            s1_valid_q  <= in_xfer;
            out_valid_q <= s1_valid_q;
            if (in_xfer) begin
                s1_pg_q <= 32'(wg_q) * 32'(Q_in);
                s1_pp_q <= 32'(wp_q) * 32'(I_in);
                s1_i_q  <= I_in;
            end
            if (s1_valid_q) begin
                i_out_q <= s1_i_q;
                q_out_q <= q_sat;
            end
        end
    end

    assign p_ii = 32'(i_out_q) * 32'(i_out_q);
    assign p_qq = 32'(q_out_q) * 32'(q_out_q);
    assign c_iq = 32'(i_out_q) * 32'(q_out_q);

    assign pdiff  = pii_q - pqq_q;
    assign g_step = (pdiff >>> EST_SHIFT) >>> MU_SHIFT;
    assign p_step = (ciq_q >>> EST_SHIFT) >>> MU_SHIFT;
    assign g_sum  = UPD_W'(wg_q) + UPD_W'(g_step);
    assign p_sum  = UPD_W'(wp_q) - UPD_W'(p_step);

    // Clamp the adapted coefficients to their legal ranges
    always_comb begin
        if (g_sum > UPD_W'(GAIN_MAX)) begin
            g_new = 16'(GAIN_MAX);
        end else if (g_sum < UPD_W'(GAIN_MIN)) begin
            g_new = 16'(GAIN_MIN);
        end else begin
            g_new = g_sum[15:0];
        end
        if (p_sum > UPD_W'(PHASE_MAX)) begin
            p_new = 16'(PHASE_MAX);
        end else if (p_sum < UPD_W'(PHASE_MIN)) begin
            p_new = 16'(PHASE_MIN);
        end else begin
            p_new = p_sum[15:0];
        end
    end

    // Estimator next state; a direct load overrides everything else
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pii_d   = pii_q;
        pqq_d   = pqq_q;
        ciq_d   = ciq_q;
        wg_d    = wg_q;
        wp_d    = wp_q;
        unique case (state_q)
            StAccum: begin
                if (out_xfer) begin
                    pii_d = pii_q + ACC_W'(p_ii);
                    pqq_d = pqq_q + ACC_W'(p_qq);
                    ciq_d = ciq_q + ACC_W'(c_iq);
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        state_d = StUpdate;
                    end else begin
                        cnt_d = cnt_q + LOG2_N'(1);
                    end
                end
            end
            StUpdate: begin
                if (est_en) begin
                    wg_d = g_new;
                    wp_d = p_new;
                end
                // A sample leaving during the update cycle opens the next block
                pii_d   = out_xfer ? ACC_W'(p_ii) : '0;
                pqq_d   = out_xfer ? ACC_W'(p_qq) : '0;
                ciq_d   = out_xfer ? ACC_W'(c_iq) : '0;
                cnt_d   = out_xfer ? LOG2_N'(1) : '0;
                state_d = StAccum;
            end
            default: state_d = StAccum;
        endcase
        if (coef_ld) begin
            wg_d    = coef_gain_in;
            wp_d    = coef_phase_in;
            pii_d   = '0;
            pqq_d   = '0;
            ciq_d   = '0;
            cnt_d   = '0;
            state_d = StAccum;
        end
    end

    // Estimator and coefficient state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            pii_q   <= '0;
            pqq_q   <= '0;
            ciq_q   <= '0;
            wg_q    <= 16'(Q14_ONE);
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pii_q   <= pii_d;
            pqq_q   <= pqq_d;
            ciq_q   <= ciq_d;
            wg_q    <= wg_d;
            wp_q    <= wp_d;
        end
    end

    assign I_out      = i_out_q;
    assign Q_out      = q_out_q;
    assign out_valid  = out_valid_q;
    assign w_gain     = wg_q;
    assign w_phase    = wp_q;
    assign block_done = (state_q == StUpdate);

endmodule

// File: tb/tb_iq_mismatch_comp.sv
// Self-checking bench for iq_mismatch_comp with a transaction-level model.
module tb_iq_mismatch_comp;

    localparam int LOG2_N   = 4;
    localparam int MU_SHIFT = 4;
    localparam int N_BLK    = 1 << LOG2_N;
    localparam int EST_SH   = LOG2_N + 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] I_in, Q_in, I_out, Q_out;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic               est_en, coef_ld, block_done;
    logic signed [15:0] coef_gain_in, coef_phase_in, w_gain, w_phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: coefficients, block sums and expected outputs in order
    longint m_wg, m_wp, m_pii, m_pqq, m_ciq;
    int     m_cnt;
    bit     m_pending;
    int     exp_i[$];
    int     exp_q[$];

    iq_mismatch_comp #(
        .LOG2_N   (LOG2_N),
        .MU_SHIFT (MU_SHIFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .I_in          (I_in),
        .Q_in          (Q_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .I_out         (I_out),
        .Q_out         (Q_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .est_en        (est_en),
        .coef_ld       (coef_ld),
        .coef_gain_in  (coef_gain_in),
        .coef_phase_in (coef_phase_in),
        .w_gain        (w_gain),
        .w_phase       (w_phase),
        .block_done    (block_done)
    );

    always #5 clk = ~clk;

    function automatic longint clampl(longint v, longint lo, longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int model_q(longint wg, longint wp, int i, int q);
        longint s;
        s = wg * q + wp * i;
        s = s >>> 14;
        return int'(clampl(s, -32768, 32767));
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        coef_ld  = 1'b0;
        est_en   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_wg = 16384; m_wp = 0; m_pii = 0; m_pqq = 0; m_ciq = 0;
        m_cnt = 0; m_pending = 0;
        exp_i.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; I_in = 16'sd1234; Q_in = 16'sd77;
        out_ready = 1'b1; est_en = 1'b0; coef_ld = 1'b0;
        coef_gain_in = '0; coef_phase_in = '0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0 || I_out !== 16'sd0 || Q_out !== 16'sd0 || block_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs got ov=%b i=%0d q=%0d bd=%b want 0", out_valid, I_out, Q_out,
                     block_done);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (w_gain !== 16'sd16384 || w_phase !== 16'sd0) begin
            n_fail++; $display("FAIL rel_coef got g=%0d p=%0d want 16384 0", w_gain, w_phase);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rel_hs got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        est_en = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; I_in = 16'sd16384; Q_in = -16'sd8192;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat1 got ov=%b want 0", out_valid); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || I_out !== 16'sd16384 || Q_out !== -16'sd8192) begin
            n_fail++;
            $display("FAIL pass got ov=%b i=%0d q=%0d want 1 16384 -8192", out_valid, I_out, Q_out);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        coef_ld = 1'b1; coef_gain_in = 16'sd32767; coef_phase_in = 16'sd16383;
        @(negedge clk);
        coef_ld = 1'b0;
        n_checks++;
        if (w_gain !== 16'sd32767 || w_phase !== 16'sd16383) begin
            n_fail++; $display("FAIL coef_ld got g=%0d p=%0d want 32767 16383", w_gain, w_phase);
        end
        in_valid = 1'b1; I_in = 16'sd32767; Q_in = 16'sd32767;
        @(negedge clk);
        I_in = -16'sd32768; Q_in = -16'sd32768;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || I_out !== 16'sd32767 || Q_out !== 16'sd32767) begin
            n_fail++;
            $display("FAIL sat_pos got ov=%b i=%0d q=%0d want 1 32767 32767", out_valid, I_out, Q_out);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || I_out !== -16'sd32768 || Q_out !== -16'sd32768) begin
            n_fail++;
            $display("FAIL sat_neg got ov=%b i=%0d q=%0d want 1 -32768 -32768", out_valid, I_out,
                     Q_out);
        end
    endtask

    task automatic test_block_period();
        int p[3];
        int np;
        do_reset();
        np = 0;
        in_valid = 1'b1; I_in = 16'sd1000; Q_in = 16'sd500; out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            if (block_done && np < 3) begin
                p[np] = cyc;
                np++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (np < 3) begin
            n_fail++; $display("FAIL blk_timeout got pulses=%0d want 3", np);
        end else begin
            n_checks++;
            if (p[1] - p[0] != N_BLK + 1 || p[2] - p[1] != N_BLK + 1) begin
                n_fail++;
                $display("FAIL blk_period got %0d %0d want %0d", p[1] - p[0], p[2] - p[1], N_BLK + 1);
            end
        end
    endtask

    // Runs random or scripted traffic against the model; mode 0 random, mode 1 long stall
    task automatic run_traffic(input int n_cycles, input int mode, input int n_drain);
        bit prev_in_xfer, prev_stall, in_xfer, out_xfer;
        longint ei, eq;
        prev_in_xfer = 1'b1;
        prev_stall   = 1'b0;
        for (int cyc = 0; cyc < n_cycles + n_drain; cyc++) begin
            @(negedge clk);
            if (!in_valid || prev_in_xfer) begin
                in_valid = (cyc < n_cycles) && (mode == 1 || $urandom_range(0, 9) < 8);
                I_in = 16'($urandom);
                Q_in = 16'($urandom);
            end
            coef_ld = 1'b0;
            if (cyc >= n_cycles) begin
                out_ready = 1'b1;
            end else if (mode == 0) begin
                out_ready = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 99) == 0) est_en = !est_en;
                if ($urandom_range(0, 299) == 0) begin
                    coef_ld = 1'b1;
                    coef_gain_in  = 16'($urandom_range(8192, 32767));
                    coef_phase_in = 16'(int'($urandom_range(0, 32767)) - 16384);
                end
            end else begin
                out_ready = !(cyc >= 20 && cyc < 25);
            end
            #1;
            n_checks++;
            if (longint'(w_gain) !== m_wg || longint'(w_phase) !== m_wp) begin
                n_fail++;
                $display("FAIL coef cyc=%0d got g=%0d p=%0d want g=%0d p=%0d", cyc, w_gain, w_phase,
                         m_wg, m_wp);
            end
            n_checks++;
            if (block_done !== m_pending) begin
                n_fail++; $display("FAIL block_done cyc=%0d got=%b want=%b", cyc, block_done, m_pending);
            end
            if (m_pending) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL upd_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_valid cyc=%0d got=%b want=1", cyc, out_valid);
                end
            end
            in_xfer  = in_valid && in_ready;
            out_xfer = out_valid && out_ready;
            if (in_xfer) begin
                exp_i.push_back(int'(I_in));
                exp_q.push_back(model_q(m_wg, m_wp, int'(I_in), int'(Q_in)));
            end
            if (m_pending) begin
                if (est_en && !coef_ld) begin
                    m_wg = clampl(m_wg + (((m_pii - m_pqq) >>> EST_SH) >>> MU_SHIFT), 8192, 32767);
                    m_wp = clampl(m_wp - ((m_ciq >>> EST_SH) >>> MU_SHIFT), -16384, 16383);
                end
                m_pii = 0; m_pqq = 0; m_ciq = 0; m_cnt = 0; m_pending = 1'b0;
            end
            if (out_valid) begin
                n_checks++;
                if (exp_i.size() == 0) begin
                    n_fail++; $display("FAIL extra_out cyc=%0d got i=%0d q=%0d want none", cyc, I_out,
                                       Q_out);
                end else if (int'(I_out) !== exp_i[0] || int'(Q_out) !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL data cyc=%0d got i=%0d q=%0d want i=%0d q=%0d", cyc, I_out, Q_out,
                             exp_i[0], exp_q[0]);
                end
                if (out_xfer && exp_i.size() != 0) begin
                    ei = exp_i.pop_front();
                    eq = exp_q.pop_front();
                    m_pii += ei * ei;
                    m_pqq += eq * eq;
                    m_ciq += ei * eq;
                    m_cnt++;
                    if (m_cnt == N_BLK) begin
                        m_cnt = 0;
                        m_pending = 1'b1;
                    end
                end
            end
            if (coef_ld) begin
                m_wg = longint'(coef_gain_in);
                m_wp = longint'(coef_phase_in);
                m_pii = 0; m_pqq = 0; m_ciq = 0; m_cnt = 0; m_pending = 1'b0;
            end
            prev_in_xfer = in_xfer;
            prev_stall   = out_valid && !out_ready;
        end
        coef_ld = 1'b0;
        n_checks++;
        if (exp_i.size() != 0) begin
            n_fail++; $display("FAIL lost_samples got pending=%0d want 0", exp_i.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        est_en = 1'b1;
        run_traffic(120, 1, 20);
    endtask

    task automatic test_random_adapt();
        do_reset();
        est_en = 1'b1;
        run_traffic(3000, 0, 40);
    endtask

    task automatic test_mid_reset();
        int cnt;
        bit seen;
        do_reset();
        in_valid = 1'b1; I_in = 16'sd1000; Q_in = 16'sd500; out_ready = 1'b1;
        coef_ld = 1'b1; coef_gain_in = 16'sd20000; coef_phase_in = -16'sd300;
        @(negedge clk);
        coef_ld = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (w_gain !== 16'sd16384 || w_phase !== 16'sd0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
            block_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst got g=%0d p=%0d ov=%b ir=%b bd=%b want 16384 0 0 0 0", w_gain,
                     w_phase, out_valid, in_ready, block_done);
        end
        rst_n = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            @(negedge clk);
            if (block_done) seen = 1'b1;
            else if (out_valid && out_ready) cnt++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!seen || cnt != N_BLK) begin
            n_fail++; $display("FAIL midrst_count got seen=%b n=%0d want 1 %0d", seen, cnt, N_BLK);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_block_period();
        test_stall();
        test_random_adapt();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
